// File: rtl/regfile_dump_reader_pkg.sv
// regdump_pkg: shared definitions for the register-file dump reader.
//   state_e      - dump FSM states (IDLE, RUN, DRAIN, DONE)
//   XZR_IDX      - index of the zero register (X31)
//   DEF_NUM_REGS - default number of registers walked
//   DEF_ADDR_W   - default register address width
package regdump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int XZR_IDX      = 31;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = 5;

endpackage

// File: rtl/regfile_dump_reader_skid.sv
// regdump_skid: 2-entry FIFO holding {index, data} beats between the
// register file read port and the streaming output.
//   clk, rst_n             - clock, asynchronous active-low reset
//   push_i                 - write push_index_i/push_data_i this cycle
//   pop_i                  - drop the head entry this cycle
//   count_o                - occupancy (0..2)
//   head_index_o/head_data_o - head entry (zero after reset)
// The caller never pushes into a full buffer without a same-cycle pop.
module regdump_skid #(
  parameter int ADDR_W = 5,
  parameter int WORD   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_index_i,
  input  logic [WORD-1:0]   push_data_i,
  input  logic              pop_i,
  output logic [1:0]        count_o,
  output logic [ADDR_W-1:0] head_index_o,
  output logic [WORD-1:0]   head_data_o
);

  logic [ADDR_W-1:0] idx_q [2];
  logic [WORD-1:0]   dat_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        idx_q[i] <= '0;
        dat_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        idx_q[wr_ptr_q] <= push_index_i;
        dat_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign head_index_o = idx_q[rd_ptr_q];
  assign head_data_o  = dat_q[rd_ptr_q];

endmodule

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks the register file read port from X0 upward on a
// start pulse and streams {index, data} beats on a valid/ready interface.
//   clk, rst_n        - clock, asynchronous active-low reset
//   start_i           - begin a dump (only honoured in IDLE)
//   busy_o            - dump in progress (cycle after start through DONE)
//   done_o            - one-cycle pulse after the last beat handshakes
//   read_register_o   - regfile read address (holds when not issuing)
//   read_data_i       - regfile data for the address on read_register_o
//   out_valid_o/out_ready_i - output handshake
//   out_index_o/out_data_o  - current beat
// Configuration macro: REGDUMP_SKIP_XZR_EN - when defined, X31 is not walked.
//
// state | meaning
// IDLE  | waiting for start_i; a start issues address 0 in the same cycle
// RUN   | issuing addresses while the buffer has room
// DRAIN | last address issued; waiting for in-flight read and buffer to empty
// DONE  | one cycle, pulses done_o
`ifndef WORD
`define WORD 64
`endif

module regfile_dump_reader
  import regdump_pkg::*;
#(
  parameter int WORD     = `WORD,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] read_register_o,
  input  logic [WORD-1:0]   read_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_index_o,
  output logic [WORD-1:0]   out_data_o
);

`ifdef REGDUMP_SKIP_XZR_EN
  localparam int LAST = (NUM_REGS - 1 < XZR_IDX - 1) ? NUM_REGS - 1 : XZR_IDX - 1;
`else
  localparam int LAST = NUM_REGS - 1;
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] read_register_q, read_register_d;
  logic              inflight_q;
  logic              issue, pop, can_issue, last_issue;
  logic [1:0]        buf_count;
  logic [2:0]        occupancy;
  logic [ADDR_W-1:0] issue_addr;

  // Occupancy counts a same-cycle pop as already gone, so a free-running
  // sink keeps one read in flight and one beat buffered with no bubbles.
  assign pop        = out_valid_o && out_ready_i;
  assign occupancy  = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign can_issue  = (occupancy < 3'd2);
  assign issue_addr = (state_q == ST_IDLE) ? '0 : rd_addr_q;
  assign last_issue = (issue_addr == LAST_ADDR);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = last_issue ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (issue && last_issue) state_d = ST_DRAIN;
      ST_DRAIN: if (occupancy == 3'd0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    issue  = 1'b0;
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      ST_IDLE:  issue = start_i;
      ST_RUN:   begin issue = can_issue; busy_o = 1'b1; end
      ST_DRAIN: busy_o = 1'b1;
      ST_DONE:  begin busy_o = 1'b1; done_o = 1'b1; end
      default:  issue = 1'b0;
    endcase
  end

  always_comb begin
    rd_addr_d       = rd_addr_q;
    read_register_d = read_register_q;
    if (issue) begin
      rd_addr_d       = issue_addr + ADDR_W'(1);
      read_register_d = issue_addr;
    end
  end

  // The address registered here is what the regfile sees next cycle; its
  // data comes back that cycle and is pushed at the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q       <= '0;
      read_register_q <= '0;
      inflight_q      <= 1'b0;
    end else begin
      rd_addr_q       <= rd_addr_d;
      read_register_q <= read_register_d;
      inflight_q      <= issue;
    end
  end

  assign read_register_o = read_register_q;

  regdump_skid #(
    .ADDR_W (ADDR_W),
    .WORD   (WORD)
  ) u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (inflight_q),
    .push_index_i (read_register_q),
    .push_data_i  (read_data_i),
    .pop_i        (pop),
    .count_o      (buf_count),
    .head_index_o (out_index_o),
    .head_data_o  (out_data_o)
  );

  assign out_valid_o = (buf_count != 2'd0);

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;

`ifdef REGDUMP_SKIP_XZR_EN
  localparam int LAST = 30;
`else
  localparam int LAST = 31;
`endif

  localparam int M_FREE    = 0;
  localparam int M_TOGGLE  = 1;
  localparam int M_STALL   = 2;
  localparam int M_RESTART = 3;
  localparam int M_RESET   = 4;

  typedef struct packed {
    logic [4:0]  idx;
    logic [63:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [4:0]  read_register;
  logic [63:0] read_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_index;
  logic [63:0] out_data;

  logic [63:0] mem [32];

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    beats    = 0;
  int    dones    = 0;
  bit    prev_stall = 1'b0;

  always #5 clk = ~clk;

  // Register file model: data for the registered address is valid during
  // the cycle that address is presented.
  assign read_data = mem[read_register];

  regfile_dump_reader dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start),
    .busy_o          (busy),
    .done_o          (done),
    .read_register_o (read_register),
    .read_data_i     (read_data),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_index_o     (out_index),
    .out_data_o      (out_data)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      M_TOGGLE: return (k % 2) == 1;
      M_STALL:  return !(k >= 2 && k <= 11);
      default:  return 1'b1;
    endcase
  endfunction

  // Scoreboard monitor: every presented beat must match the queue head,
  // including every cycle it is held under backpressure.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("valid_held", {63'd0, out_valid}, 64'd1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: actual index %0d, expected no beat", out_index);
        end else begin
          check("beat_index", {59'd0, out_index}, {59'd0, exp_q[0].idx});
          check("beat_data", out_data, exp_q[0].data);
          if (out_ready) begin
            void'(exp_q.pop_front());
            beats++;
          end
        end
      end
      if (done) dones++;
      prev_stall = out_valid && !out_ready;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      {63'd0, busy}, 64'd0);
    check({tag, "_done"},      {63'd0, done}, 64'd0);
    check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_out_index"}, {59'd0, out_index}, 64'd0);
    check({tag, "_out_data"},  out_data, 64'd0);
    check({tag, "_read_reg"},  {59'd0, read_register}, 64'd0);
  endtask

  task automatic run_dump(input int mode);
    int done_cyc;
    int first_cyc;
    bit restarted;
    bit start_next;
    bit aborted;
    done_cyc   = -1;
    first_cyc  = -1;
    restarted  = 1'b0;
    start_next = 1'b0;
    aborted    = 1'b0;
    beats = 0;
    dones = 0;
    for (int i = 0; i <= LAST; i++) exp_q.push_back('{idx: 5'(i), data: 64'(1000 + i)});

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);             // edge E0
    #1;
    start     = 1'b0;
    out_ready = ready_for(mode, 1);

    for (int k = 1; k <= 300 && done_cyc < 0 && !aborted; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("c1_read_register", {59'd0, read_register}, 64'd0);
        check("c1_busy", {63'd0, busy}, 64'd1);
        check("c1_out_valid", {63'd0, out_valid}, 64'd0);
      end
      if (out_valid && first_cyc < 0) first_cyc = k;
      if (done) done_cyc = k;
      // Beats 0 and 1 fill the buffer; the issue counter parks at 2, so the
      // last address driven is 1 and the head stays on beat 0.
      if (mode == M_STALL && k == 11) begin
        check("stall_read_register", {59'd0, read_register}, 64'd1);
        check("stall_out_index", {59'd0, out_index}, 64'd0);
        check("stall_out_valid", {63'd0, out_valid}, 64'd1);
      end
      if (mode == M_RESTART && !restarted && out_valid && out_index == 5'd5) begin
        restarted  = 1'b1;
        start_next = 1'b1;
      end
      if (mode == M_RESET && out_valid && out_index == 5'd12) begin
        #1 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        aborted = 1'b1;
      end
      if (!aborted) begin
        @(posedge clk);
        #1;
        out_ready  = ready_for(mode, k + 1);
        start      = start_next;
        start_next = 1'b0;
      end
    end
    start = 1'b0;

    if (aborted) begin
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_busy", {63'd0, busy}, 64'd0);
    end else if (done_cyc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: actual no done, expected done within 300 cycles (mode %0d)", mode);
    end else begin
      @(negedge clk);
      check("busy_after_done", {63'd0, busy}, 64'd0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      check("beats_total", 64'(beats), 64'(LAST + 1));
      check("done_pulses", 64'(dones), 64'd1);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      check("first_beat_cycle", 64'(first_cyc), 64'd2);
      if (mode == M_FREE || mode == M_RESTART)
        check("done_cycle", 64'(done_cyc), 64'(LAST + 3));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 64'(1000 + i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    run_dump(M_FREE);
    run_dump(M_TOGGLE);
    run_dump(M_STALL);
    run_dump(M_RESTART);
    run_dump(M_RESET);
    run_dump(M_FREE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
